// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake of the immediate-generation stage
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     Instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_data;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  modport slave (input in_valid, Instr, out_ready, output in_ready, out_valid, imm_data, out_fmt, out_illegal);
  modport master (output in_valid, Instr, out_ready, input in_ready, out_valid, imm_data, out_fmt, out_illegal);
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32/RV64 immediate decode with valid/ready, optional skid entry and illegal counter
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter bit SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;
  ent_t dec, out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d, push, pop;
  logic is_i, is_s, is_b, is_u, is_j;
  logic [6:0] op;
  logic [31:0] ins, imm32;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign ins = bus.Instr;
  always_comb begin
    op = ins[6:0];
    is_i = op inside {7'h03, 7'h13, 7'h67};
    is_s = op == 7'h23;
    is_b = op == 7'h63;
    is_u = op inside {7'h37, 7'h17};
    is_j = op == 7'h6f;
    imm32 = is_i ? {{20{ins[31]}}, ins[31:20]} :
            is_s ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
            is_b ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
            is_u ? {ins[31:12], 12'b0} :
            is_j ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} : '0;
    dec.imm = XLEN'($signed(imm32));
    dec.fmt = is_i ? 3'd1 : is_s ? 3'd2 : is_b ? 3'd3 : is_u ? 3'd4 : is_j ? 3'd5 : 3'd0;
    dec.ill = !(is_i || is_s || is_b || is_u || is_j);
  end
  // With SKID the ready is a pure register output, cutting the out_ready -> in_ready path
  assign bus.in_ready = SKID ? !skid_v_q : (!out_v_q || bus.out_ready);
  always_comb begin
    push = bus.in_valid && bus.in_ready;
    pop = out_v_q && bus.out_ready;
    out_v_d = out_v_q;
    out_d = out_q;
    skid_v_d = skid_v_q;
    skid_d = skid_q;
    if (!out_v_q || pop) begin
      out_v_d = skid_v_q || push;
      out_d = skid_v_q ? skid_q : push ? dec : out_q;
      skid_v_d = 1'b0;
    end else if (push) begin
      skid_v_d = 1'b1;
      skid_d = dec;
    end
    cnt_d = clr_cnt ? '0 : (push && dec.ill && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q <= 1'b0;
      out_q <= '0;
      skid_v_q <= 1'b0;
      skid_q <= '0;
      cnt_q <= '0;
    end else begin
      out_v_q <= out_v_d;
      out_q <= out_d;
      skid_v_q <= skid_v_d;
      skid_q <= skid_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.out_valid = out_v_q;
  assign bus.imm_data = out_q.imm;
  assign bus.out_fmt = out_q.fmt;
  assign bus.out_illegal = out_q.ill;
  assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table + scoreboard bench; SKID=1/XLEN=32 main DUT and SKID=0/XLEN=64/CNT_W=2 side DUT
module tb_imm_gen_pipe;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;
  logic clk = 0, rst_n = 0, clr_cnt = 0, clr2 = 0;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int checks = 0, errors = 0, cyc = 0, exp_cnt = 0, c0 = 0;
  vec_t q[$];
  vec_t vt[14];
  vec_t e;
  vec_t ill0;
  logic stall_p = 0;
  logic [31:0] h_imm;
  logic [2:0] h_fmt;
  logic h_ill;

  imm_gen_pipe_if #(.XLEN(32)) b1();
  imm_gen_pipe_if #(.XLEN(64)) b2();
  imm_gen_pipe #(.XLEN(32), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1), .clr_cnt(clr_cnt), .illegal_cnt(cnt));
  imm_gen_pipe #(.XLEN(64), .SKID(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .clr_cnt(clr2), .illegal_cnt(cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    b1.in_valid = 1;
    b1.Instr = v.instr;
    do begin @(negedge clk); n++; end while (!b1.in_ready && n < 50);
    if (!b1.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout instr=%h actual=in_ready_low required=accept", v.instr);
    end else begin
      q.push_back(v);
      if (v.ill) exp_cnt++;
    end
    @(posedge clk); #1 b1.in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
    end
  endtask

  // Scoreboard pop on each transfer, plus hold-stability while stalled
  always @(negedge clk) begin
    if (!rst_n) stall_p = 0;
    else begin
      if (stall_p) begin
        chk("hold_valid", b1.out_valid, 1);
        chk("hold_imm", b1.imm_data, h_imm);
        chk("hold_fmt", b1.out_fmt, h_fmt);
        chk("hold_ill", b1.out_illegal, h_ill);
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual=imm %h required=no_output", b1.imm_data);
        end else begin
          e = q.pop_front();
          chk("sb_imm", b1.imm_data, e.imm);
          chk("sb_fmt", b1.out_fmt, e.fmt);
          chk("sb_ill", b1.out_illegal, e.ill);
        end
      end
      stall_p = b1.out_valid && !b1.out_ready;
      h_imm = b1.imm_data;
      h_fmt = b1.out_fmt;
      h_ill = b1.out_illegal;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
    vt[1]  = '{32'h00000463, 32'h00000008, 3'd3, 1'b0};
    vt[2]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
    vt[3]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0};
    vt[4]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
    vt[5]  = '{32'h80000017, 32'h80000000, 3'd4, 1'b0};
    vt[6]  = '{32'h7FF02083, 32'h000007FF, 3'd1, 1'b0};
    vt[7]  = '{32'h80000067, 32'hFFFFF800, 3'd1, 1'b0};
    vt[8]  = '{32'hFE000FE3, 32'hFFFFFFFE, 3'd3, 1'b0};
    vt[9]  = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0};
    vt[10] = '{32'h000000E3, 32'h00000800, 3'd3, 1'b0};
    vt[11] = '{32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b1};
    vt[12] = '{32'h0000000B, 32'h00000000, 3'd0, 1'b1};
    vt[13] = '{32'h00000013, 32'h00000000, 3'd1, 1'b0};
    ill0   = '{32'h00000000, 32'h00000000, 3'd0, 1'b1};
    b1.in_valid = 0; b1.Instr = 0; b1.out_ready = 1;
    b2.in_valid = 0; b2.Instr = 0; b2.out_ready = 1;
    #12;
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_imm", b1.imm_data, 0);
    chk("rst_fmt", b1.out_fmt, 0);
    chk("rst_ill", b1.out_illegal, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst2_out_valid", b2.out_valid, 0);
    chk("rst2_cnt", cnt2, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("in_ready_after_rst", b1.in_ready, 1);
    @(posedge clk); #1;
    // T1: one-cycle latency
    send(vt[0]);
    @(negedge clk);
    chk("t1_valid", b1.out_valid, 1);
    chk("t1_imm", b1.imm_data, 32'hFFFFFFFF);
    chk("t1_fmt", b1.out_fmt, 1);
    @(posedge clk); #1;
    // Full vector table streamed back to back
    c0 = cyc;
    foreach (vt[i]) send(vt[i]);
    chk("throughput_cycles", 64'(cyc - c0), 14);
    drain();
    chk("cnt_after_table", cnt, 64'(exp_cnt));
    // T3: stall with three offered instructions
    @(posedge clk); #1 b1.out_ready = 0;
    fork
      begin send(vt[2]); send(vt[3]); send(vt[4]); end
      begin
        repeat (3) @(negedge clk);
        chk("t3_in_ready_full", b1.in_ready, 0);
        repeat (3) @(posedge clk);
        #1 b1.out_ready = 1;
      end
    join
    drain();
    @(negedge clk); chk("t3_idle_after", b1.out_valid, 0);
    // T4: illegal counter and clear priority
    @(posedge clk); #1 clr_cnt = 1;
    @(posedge clk); #1 clr_cnt = 0; exp_cnt = 0;
    @(negedge clk); chk("clr_alone", cnt, 0);
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) begin
      send(ill0);
      @(negedge clk); chk("t4_cnt", cnt, 64'(i));
      @(posedge clk); #1;
    end
    clr_cnt = 1;
    send(ill0);
    clr_cnt = 0; exp_cnt = 0;
    @(negedge clk); chk("t4_clr_wins", cnt, 0);
    drain();
    // T5: asynchronous reset while full
    @(posedge clk); #1 b1.out_ready = 0;
    send(ill0); send(ill0);
    @(negedge clk);
    chk("t5_full", b1.in_ready, 0);
    chk("t5_cnt_pre", cnt, 2);
    #2 rst_n = 0;
    #1;
    chk("t5_async_valid", b1.out_valid, 0);
    chk("t5_async_cnt", cnt, 0);
    q.delete(); exp_cnt = 0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1; b1.out_ready = 1;
    @(negedge clk); chk("t5_in_ready", b1.in_ready, 1);
    repeat (3) begin @(negedge clk); chk("t5_no_stale", b1.out_valid, 0); end
    // SKID=0, XLEN=64, CNT_W=2
    @(posedge clk); #1 b2.in_valid = 1; b2.Instr = 32'h00000463;
    @(negedge clk); chk("s0_in_ready", b2.in_ready, 1);
    @(posedge clk); #1 b2.Instr = 32'h123450B7;
    @(negedge clk); chk("x64_b_imm", b2.imm_data, 64'h8); chk("x64_b_fmt", b2.out_fmt, 3);
    @(posedge clk); #1 b2.Instr = 32'hFFDFF06F;
    @(negedge clk); chk("x64_u_imm", b2.imm_data, 64'h12345000); chk("x64_u_fmt", b2.out_fmt, 4);
    @(posedge clk); #1 b2.in_valid = 0;
    @(negedge clk); chk("x64_j_imm", b2.imm_data, 64'hFFFFFFFFFFFFFFFC); chk("x64_j_fmt", b2.out_fmt, 5);
    @(posedge clk); #1 b2.in_valid = 1; b2.Instr = 32'hFFF00093; b2.out_ready = 0;
    @(negedge clk); chk("s0_ready_empty", b2.in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("x64_i_imm", b2.imm_data, 64'hFFFFFFFFFFFFFFFF);
    chk("s0_ready_stalled", b2.in_ready, 0);
    @(posedge clk); #1 b2.Instr = 32'h0; b2.out_ready = 1;
    #1 chk("s0_ready_comb", b2.in_ready, 1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk("s0_cnt_sat", cnt2, (i > 3) ? 3 : i);
      chk("s0_ill", b2.out_illegal, 1);
      chk("s0_ill_imm", b2.imm_data, 0);
    end
    b2.in_valid = 0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
